// File: rtl/mem_skew_feeder.sv
// -----------------------------------------------------------------------------
// mem_skew_feeder
//
// Read-side sequencer for the 4x4 operand memory. One start request runs one
// 16-element tile. Column c is read in steps t = c..c+3, so successive columns
// start one step later than their neighbour. The returned data is registered
// into four aligned lanes for the systolic array input edge.
//
// Optional build macro: MEM_SKEW_FEEDER_STALL_EN
//   When defined, a stall input freezes the wavefront. While stall is high in
//   RUN, the step counter holds and no column is read. While stall is high in
//   DRAIN, the block stays in DRAIN and done is held low. When the macro is
//   undefined there is no stall port, and the block behaves as if stall were 0.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset; has priority over start
//   start      request one tile feed; sampled only in IDLE
//   stall      (MEM_SKEW_FEEDER_STALL_EN only) freeze the wavefront
//   busy       high in RUN and DRAIN
//   done       one-cycle pulse in the final (DRAIN) cycle of a tile
//   rd_en      per-column memory read enable
//   rd_elem    per-column row select, bits [2c+1:2c] belong to column c
//   mem_data   combinational memory read data, lane c = bits [DW*(c+1)-1:DW*c]
//   feed_data  registered lane data, same packing as mem_data
//   feed_valid registered per-lane valid, aligned with feed_data
//
// Handshake: start is a level request that is accepted on any rising edge where
// the block is in IDLE. busy covers every cycle from acceptance up to and
// including the done cycle. A start that is held high is accepted again in the
// first IDLE cycle. Requests made while busy are dropped, not queued.
// -----------------------------------------------------------------------------
module mem_skew_feeder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef MEM_SKEW_FEEDER_STALL_EN
    input  logic                    stall,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              rd_en,
    output logic [7:0]              rd_elem,
    input  logic [4*DATA_WIDTH-1:0] mem_data,
    output logic [4*DATA_WIDTH-1:0] feed_data,
    output logic [3:0]              feed_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Last step of the wavefront. Column 3 finishes its row 3 here.
    localparam logic [2:0] T_LAST   = 3'd6;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] t;
    logic [2:0] t_nxt;
    logic       stall_i;

`ifdef MEM_SKEW_FEEDER_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    t_nxt     = 3'd0;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (t == T_LAST) begin
                        state_nxt = ST_DRAIN;
                        t_nxt     = 3'd0;
                    end else begin
                        t_nxt = t + 3'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                t_nxt     = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            t     <= 3'd0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DRAIN) && !stall_i;

    // ------------------------------------------------------------------
    // Skewed read decode.
    // Column c is active while c <= t <= c+3, and it reads row t-c.
    // This is decoded from state and t in the same cycle. There is no
    // register stage, so the memory sees the request in the current step.
    // ------------------------------------------------------------------
    logic       run_active;
    logic [3:0] t_ext;
    logic [3:0] row_diff;

    assign run_active = (state == ST_RUN) && !stall_i;
    assign t_ext      = {1'b0, t};

    always_comb begin
        rd_en    = 4'd0;
        rd_elem  = 8'd0;
        row_diff = 4'd0;
        for (int c = 0; c < 4; c++) begin
            if (run_active && (t_ext >= 4'(c)) && (t_ext <= 4'(c + 3))) begin
                row_diff           = t_ext - 4'(c);
                rd_en[c]           = 1'b1;
                rd_elem[2*c +: 2]  = row_diff[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Feed register.
    // The memory read is combinational, so the data requested in step t
    // is captured at the end of that step. Lanes that were not read are
    // zeroed, so that stale memory output never reaches the array.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            feed_valid <= 4'd0;
            feed_data  <= '0;
        end else begin
            feed_valid <= rd_en;
            for (int c = 0; c < 4; c++) begin
                if (rd_en[c]) begin
                    feed_data[DATA_WIDTH*c +: DATA_WIDTH] <= mem_data[DATA_WIDTH*c +: DATA_WIDTH];
                end else begin
                    feed_data[DATA_WIDTH*c +: DATA_WIDTH] <= '0;
                end
            end
        end
    end

endmodule
